// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode issue/stall control with a load scoreboard, redirect flush and load drain.
// Define HAZARD_PERF_CNT_EN to build the stall_cycles performance counter.
module hazard_scoreboard #(
    parameter int RegAddress  = 5,
    parameter int MaxPending  = 4,
    parameter int FlushCycles = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             id_valid,
    input  logic [RegAddress-1:0]            id_rs1,
    input  logic [RegAddress-1:0]            id_rs2,
    input  logic                             id_uses_rs1,
    input  logic                             id_uses_rs2,
    input  logic [RegAddress-1:0]            id_rd,
    input  logic                             id_reg_write,
    input  logic                             id_load,
    input  logic                             wb_valid,
    input  logic [RegAddress-1:0]            wb_rd,
    input  logic                             redirect,
    input  logic                             drain_req,
    output logic                             issue_ready,
    output logic                             stall_fetch,
    output logic                             flush_id,
    output logic                             drain_ack,
    output logic [$clog2(MaxPending+1)-1:0]  pending_count,
    output logic [31:0]                      stall_cycles
);
    localparam int NumRegs = 2 ** RegAddress;
    localparam int PendW   = $clog2(MaxPending + 1);
    localparam int FlushW  = $clog2(FlushCycles + 1);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [NumRegs-1:0] busy_q, busy_d;
    logic [PendW-1:0]   pend_q, pend_d;
    logic [FlushW-1:0]  fcnt_q, fcnt_d;
    logic               arm_q, arm_d;
    logic               hazard, full, set_en, clr_en, enter_drain;

    always_comb begin
        hazard = (id_uses_rs1 & busy_q[id_rs1]) | (id_uses_rs2 & busy_q[id_rs2])
               | (id_reg_write & busy_q[id_rd]);
        full        = pend_q == PendW'(MaxPending);
        issue_ready = 1'b0;
        stall_fetch = 1'b0;
        flush_id    = 1'b0;
        drain_ack   = 1'b0;
        if (rst) begin
            case (state_q)
                RUN: begin
                    issue_ready = ~hazard & ~(id_load & full);
                    stall_fetch = id_valid & ~issue_ready;
                end
                FLUSH: flush_id = 1'b1;
                DRAIN: begin
                    stall_fetch = id_valid;
                    drain_ack   = (pend_q == '0) & ~redirect;
                end
                default: ;
            endcase
        end
    end

    // A set and a clear of the same register in one cycle leaves it busy.
    always_comb begin
        set_en = id_valid & issue_ready & id_load & id_reg_write & (id_rd != '0);
        clr_en = wb_valid & busy_q[wb_rd];
        busy_d = busy_q;
        if (clr_en) busy_d[wb_rd] = 1'b0;
        if (set_en) busy_d[id_rd] = 1'b1;
        pend_d = pend_q + PendW'(set_en) - PendW'(clr_en);
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        enter_drain = 1'b0;
        if (redirect) begin
            state_d = FLUSH;
            fcnt_d  = FlushW'(FlushCycles - 1);
        end else begin
            case (state_q)
                RUN: begin
                    enter_drain = drain_req & arm_q;
                    state_d     = enter_drain ? DRAIN : RUN;
                end
                FLUSH: begin
                    state_d = (fcnt_q == '0) ? RUN : FLUSH;
                    fcnt_d  = (fcnt_q == '0) ? fcnt_q : fcnt_q - FlushW'(1);
                end
                DRAIN:   state_d = drain_ack ? RUN : DRAIN;
                default: state_d = RUN;
            endcase
        end
        // A drain needs drain_req to have been seen low since the last entry.
        arm_d = ~drain_req | (arm_q & ~enter_drain);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            busy_q  <= '0;
            pend_q  <= '0;
            fcnt_q  <= '0;
            arm_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            fcnt_q  <= fcnt_d;
            arm_q   <= arm_d;
        end
    end

    assign pending_count = pend_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = (id_valid & ~issue_ready & ~flush_id & ~&stall_cycles_q)
                       ? stall_cycles_q + 32'd1 : stall_cycles_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) stall_cycles_q <= '0;
        else      stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = '0;
`endif
endmodule
